// File: rtl/fairy_dsram_resp_if.sv
// Data-SRAM request/response bundle between the data cache (master) and
// the memory-side responder (slave). Single-cycle requests, no handshake.
interface fairy_dsram_resp_if;
  logic [31:0] data_sram_addr_i;
  logic [3:0]  data_sram_cen_i;
  logic [31:0] data_sram_wdata_i;
  logic        data_sram_wr_i;
  logic [31:0] data_sram_rdata_o;

  modport master (
    output data_sram_addr_i, data_sram_cen_i, data_sram_wdata_i, data_sram_wr_i,
    input  data_sram_rdata_o
  );

  modport slave (
    input  data_sram_addr_i, data_sram_cen_i, data_sram_wdata_i, data_sram_wr_i,
    output data_sram_rdata_o
  );
endinterface

// File: rtl/fairy_dsram_resp.sv
// Memory-side responder for the data-SRAM port. Word array, self-clearing
// after reset, one-cycle registered read data, write-first on writes, debug
// access counters and a sticky out-of-window error flag.

// One byte lane of the write merge: enabled lanes take new data.
module fairy_dsram_lane #(
  parameter int VEC_W = 8
) (
  input  logic             en,
  input  logic [VEC_W-1:0] old_b,
  input  logic [VEC_W-1:0] new_b,
  output logic [VEC_W-1:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module fairy_dsram_resp #(
  parameter int          DEPTH_LOG2 = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fairy_dsram_resp_if.slave    bus,
  output logic                 ready_o,
  output logic                 err_o,
  output logic [31:0]          rd_count_o,
  output logic [31:0]          wr_count_o
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int TAG_LSB   = DEPTH_LOG2 + 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t                             state;
  logic [DEPTH_LOG2-1:0]              init_idx;
  logic [31:0]                        rdata_q;
  logic [31:0]                        rd_count_q;
  logic [31:0]                        wr_count_q;
  logic                               err_q;
  logic                               ready_q;

  logic [31:0]                        mem [DEPTH];

  logic [DEPTH_LOG2-1:0]              idx;
  logic                               in_win;
  logic                               any_lane;
  logic                               run_wr;
  logic                               run_rd_cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]    old_word;
  logic [NUM_LANES-1:0][VEC_W-1:0]    new_word;
  logic [NUM_LANES-1:0][VEC_W-1:0]    merged;
  logic [1:0]                         unused_addr_lsb;

  assign unused_addr_lsb = bus.data_sram_addr_i[1:0];

  assign idx      = bus.data_sram_addr_i[TAG_LSB-1:2];
  assign in_win   = (bus.data_sram_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign any_lane = |bus.data_sram_cen_i;
  assign old_word = mem[idx];
  assign new_word = bus.data_sram_wdata_i;

  // A write with no lanes enabled merges to the old word, so it is
  // harmless to gate the array write on any_lane only.
  assign run_wr     = (state == RUN) &&  bus.data_sram_wr_i && in_win && any_lane;
  assign run_rd_cnt = (state == RUN) && !bus.data_sram_wr_i && in_win && any_lane;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      fairy_dsram_lane #(.VEC_W(VEC_W)) u_lane (
        .en    (bus.data_sram_cen_i[g]),
        .old_b (old_word[g]),
        .new_b (new_word[g]),
        .out_b (merged[g])
      );
    end
  endgenerate

  // Array write port: clearing sweep during INIT, merged word in RUN.
  // The array reads combinationally, so a read in the cycle after a write
  // already sees the new word and no bypass register is needed.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[init_idx] <= '0;
    else if (run_wr)
      mem[idx] <= merged;
  end

  // Control FSM with registered read data, counters, ready and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      init_idx   <= '0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rdata_q  <= '0;
          init_idx <= init_idx + 1'b1;
          if (&init_idx) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (in_win)
            rdata_q <= bus.data_sram_wr_i ? merged : old_word;
          else
            rdata_q <= '0;
          if (run_rd_cnt) rd_count_q <= rd_count_q + 32'd1;
          if (run_wr)     wr_count_q <= wr_count_q + 32'd1;
          if (!in_win && (any_lane || bus.data_sram_wr_i))
            err_q <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.data_sram_rdata_o = rdata_q;
  assign ready_o               = ready_q;
  assign err_o                 = err_q;
  assign rd_count_o            = rd_count_q;
  assign wr_count_o            = wr_count_q;
endmodule

// File: doc/fairy_dsram_resp.md
# fairy_dsram_resp

Memory-side responder for the data-SRAM port driven by the data cache. It serves the cache's single-cycle SRAM-style requests (address, byte enables, write data, write strobe) from an internal word array and returns read data with a fixed one-cycle latency. It never back-pressures. After reset it clears its array, and it exposes access counters and a sticky address-error flag for debug.

## Interface
Parameters:
- DEPTH_LOG2, 13, log2 of array depth in 32-bit words (range 2..16)
- BASE_ADDR, 32'h0000_0000, byte base of the window; bits [DEPTH_LOG2+1:0] are ignored

Ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- data_sram_addr_i  in  32  byte address; bits [1:0] ignored
- data_sram_cen_i  in  4  byte enables, bit k = byte lane k ([8k+7:8k])
- data_sram_wdata_i  in  32  write data
- data_sram_wr_i  in  1  1 = write cycle, 0 = read cycle
- data_sram_rdata_o  out  32  registered read data
- ready_o  out  1  array initialised; requests honoured
- err_o  out  1  sticky: an out-of-window access occurred
- rd_count_o  out  32  count of counted reads
- wr_count_o  out  32  count of counted writes

## Operation
- Index = addr[DEPTH_LOG2+1:2].
- In window = (addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]).
- The FSM has two states: INIT and RUN. Reset forces INIT with init index 0.
- INIT:
  - Each cycle writes 32'h0 to mem[init index] and increments the index.
  - After index 2^DEPTH_LOG2-1 is written, the next state is RUN.
  - All requests are ignored: no array write, rdata_o = 0, no count, no err.
- RUN, read cycle (wr_i=0):
  - Every cycle is a read, regardless of cen_i. rdata_o(next) = mem[index] if in window, else 0.
  - rd_count increments only if cen_i != 0 and in window.
- RUN, write cycle (wr_i=1), in window:
  - Lanes with cen_i[k]=1 take wdata_i; other lanes are unchanged.
  - rdata_o(next) = the merged post-write word (write-first).
  - wr_count increments if cen_i != 0. A write with cen_i=0 changes nothing and is not counted.
- Out-of-window access in RUN:
  - Writes are dropped and reads return 0.
  - err_o is set if cen_i != 0 or wr_i=1, and stays set until reset.
  - Out-of-window accesses are not counted.
- Read-after-write:
  - A read of index I in the cycle after a write to I returns the merged new word.
  - If the array macro is read-first, this must be handled with a one-entry bypass register (index, word, valid).
- Counters wrap from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: rdata_o=0, ready_o=0, err_o=0, rd_count_o=0, wr_count_o=0, state=INIT, init index=0.
- Asserting reset mid-run returns all of the above immediately; array contents are then re-cleared by INIT.
- The first rising edge after reset_n deasserts writes index 0.
- Init takes exactly 2^DEPTH_LOG2 cycles. ready_o rises on the edge that writes the last index; the request sampled on the following edge is the first one honoured.
- Read latency is 1: the address sampled at edge N gives rdata_o valid after edge N and held until edge N+1.
  - Back-to-back reads give one word per cycle. This supports a 4-word refill burst at 4 consecutive addresses.
- A write at edge N is visible to a read sampled at edge N+1.
- Counters and err_o update on the same edge as the access.
- There is no stall output. Every RUN request completes in its cycle.

## Test plan
1. Reset/init (DEPTH_LOG2=4): deassert reset_n.
   - ready_o=0 for 16 cycles, then 1.
   - rdata_o=0 throughout init.
   - Reads of indices 0..15 return 0.
2. Burst refill: preload words 0x1000..0x100C with 11111111..44444444. Read 0x1008, 0x100C, 0x1000, 0x1004 back-to-back with cen=F.
   - rdata_o = 33333333, 44444444, 11111111, 22222222 on successive cycles.
   - rd_count_o increases by 4.
3. Byte write: word = A5A5A5A5; write wdata=12345678 with cen=0101; next cycle read the same address.
   - rdata_o after the write = A534A578.
   - The read returns A534A578.
   - wr_count_o increases by 1.
4. Out-of-window access: BASE_ADDR=0, DEPTH_LOG2=4; write to 0x0000_0040.
   - err_o=1 and stays 1.
   - Word 0 is unchanged.
   - A read of 0x40 returns 0.
   - Counters are unchanged.
5. Reset mid-run: pulse reset_n low between edges while words are nonzero.
   - All outputs are 0 immediately.
   - INIT reruns, after which a previously written word reads 0.
6. Counter wrap: force rd_count to FFFFFFFF (via 2^32 counted reads or a backdoor), then do one counted read.
   - rd_count_o = 0.
   - A read with cen=0 is not counted but still returns data.
